// File: rtl/set_event_pkg.sv
// Shared types for the set_event command block: command mode encodings,
// controller states and the slot-select width helper.
package set_event_pkg;

  typedef enum logic [1:0] {
    MODE_SET     = 2'b00,
    MODE_PULSE   = 2'b01,
    MODE_DELAYED = 2'b10,
    MODE_RSVD    = 2'b11
  } set_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_DELAY = 2'b01,
    ST_PULSE = 2'b10
  } state_e;

  // Select width never collapses to zero bits, even for a single slot.
  function automatic int sel_width(input int size);
    return (size > 1) ? $clog2(size) : 1;
  endfunction

endpackage

// File: rtl/set_event_timer.sv
// Loadable down-counter for the PULSE / DELAYED_SET hold time. It saturates at
// zero and flags both zero and the final remaining cycle.
module set_event_timer #(
  parameter int TIMER_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load,
  input  logic [TIMER_WIDTH-1:0] load_val,
  input  logic                   dec_en,
  output logic [TIMER_WIDTH-1:0] count,
  output logic                   zero,
  output logic                   last
);

  logic [TIMER_WIDTH-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_val;
    end else if (dec_en && (count_reg != '0)) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign count = count_reg;
  assign zero  = (count_reg == '0);
  assign last  = (count_reg == {{(TIMER_WIDTH-1){1'b0}}, 1'b1});

endmodule

// File: rtl/set_event.sv
// Command-driven slot driver: SET writes a slot immediately, PULSE drives a
// value for D cycles then restores, DELAYED_SET writes after D cycles.
module set_event
  import set_event_pkg::*;
#(
  parameter int                   SET_SIZE    = 5,
  parameter int                   SET_WIDTH   = 1,
  parameter int                   TIMER_WIDTH = 32,
  parameter logic [SET_WIDTH-1:0] SET_INIT    = '0
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              i_en_set,
  input  logic [sel_width(SET_SIZE)-1:0]    i_set_sel,
  input  logic [1:0]                        i_set_mode,
  input  logic [SET_WIDTH-1:0]              i_set_val,
  input  logic [TIMER_WIDTH-1:0]            i_duration,
  output logic [SET_SIZE*SET_WIDTH-1:0]     o_set_signals,
  output logic                              o_busy,
  output logic                              o_set_done,
  output logic                              o_set_err
);

  localparam int SEL_W = sel_width(SET_SIZE);

  state_e                 state_reg, state_next;
  logic [SET_WIDTH-1:0]   slots_reg [SET_SIZE];
  logic [SET_WIDTH-1:0]   slots_next [SET_SIZE];
  logic [SET_WIDTH-1:0]   val_reg, val_next;
  logic [SEL_W-1:0]       sel_reg, sel_next;
  logic                   done_reg, done_next;
  logic                   err_reg, err_next;

  logic                   timer_load;
  logic                   timer_dec;
  logic [TIMER_WIDTH-1:0] timer_load_val;
  logic [TIMER_WIDTH-1:0] timer_count;
  logic                   timer_zero;
  logic                   timer_last;
  logic                   cmd_ok;
  logic                   finishing;

  set_event_timer #(
    .TIMER_WIDTH(TIMER_WIDTH)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (timer_load),
    .load_val(timer_load_val),
    .dec_en  (timer_dec),
    .count   (timer_count),
    .zero    (timer_zero),
    .last    (timer_last)
  );

  // A zero duration behaves as one cycle.
  assign timer_load_val = (i_duration == '0) ? {{(TIMER_WIDTH-1){1'b0}}, 1'b1} : i_duration;
  assign cmd_ok         = i_en_set && (int'(i_set_sel) < SET_SIZE)
                          && (set_mode_e'(i_set_mode) != MODE_RSVD);
  // The zero term is a safety net; in normal operation completion is on the last count.
  assign finishing      = (state_reg != ST_IDLE) && (timer_last || timer_zero);

  always_comb begin
    state_next = state_reg;
    slots_next = slots_reg;
    val_next   = val_reg;
    sel_next   = sel_reg;
    done_next  = 1'b0;
    err_next   = 1'b0;
    timer_load = 1'b0;
    timer_dec  = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (cmd_ok) begin
          case (set_mode_e'(i_set_mode))
            MODE_SET: begin
              slots_next[i_set_sel] = i_set_val;
              done_next             = 1'b1;
            end
            MODE_PULSE: begin
              // val_reg holds the value to restore when the pulse ends.
              val_next              = slots_reg[i_set_sel];
              sel_next              = i_set_sel;
              slots_next[i_set_sel] = i_set_val;
              timer_load            = 1'b1;
              state_next            = ST_PULSE;
            end
            MODE_DELAYED: begin
              val_next   = i_set_val;
              sel_next   = i_set_sel;
              timer_load = 1'b1;
              state_next = ST_DELAY;
            end
            default: ;
          endcase
        end else if (i_en_set) begin
          err_next = 1'b1;
        end
      end

      ST_PULSE, ST_DELAY: begin
        timer_dec = 1'b1;
        if (finishing) begin
          slots_next[sel_reg] = val_reg;
          done_next           = 1'b1;
          state_next          = ST_IDLE;
        end else if (i_en_set) begin
          err_next = 1'b1;
        end
        // A strobe landing on the completion cycle is dropped silently so
        // that done and err never coincide.
      end

      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      for (int k = 0; k < SET_SIZE; k++) begin
        slots_reg[k] <= SET_INIT;
      end
      val_reg  <= '0;
      sel_reg  <= '0;
      done_reg <= 1'b0;
      err_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      slots_reg <= slots_next;
      val_reg   <= val_next;
      sel_reg   <= sel_next;
      done_reg  <= done_next;
      err_reg   <= err_next;
    end
  end

  generate
    for (genvar gi = 0; gi < SET_SIZE; gi++) begin : g_pack
      assign o_set_signals[gi*SET_WIDTH +: SET_WIDTH] = slots_reg[gi];
    end
  endgenerate

  assign o_busy     = (state_reg != ST_IDLE);
  assign o_set_done = done_reg;
  assign o_set_err  = err_reg;

endmodule

// File: tb/tb_set_event.sv
// Directed bench for set_event: a cycle-scheduled event model checked every
// cycle, plus hand-computed literal expectations at key cycles.
module tb_set_event;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en  = 1'b0;
  logic [2:0]  sel = '0;
  logic [1:0]  mode = '0;
  logic        val = 1'b0;
  logic [31:0] dur = '0;
  logic [4:0]  sig;
  logic        busy, done, err;

  int    total = 0;
  int    bad   = 0;
  longint cyc  = 0;

  // model state: visible slot bits, cycle at which busy drops, pending write
  logic [4:0] m_sig  = '0;
  longint     m_end  = 0;
  int         m_sel  = 0;
  logic       m_val  = 1'b0;
  logic       m_done = 1'b0;
  logic       m_err  = 1'b0;

  set_event dut (
    .clk          (clk),
    .rst          (rst),
    .i_en_set     (en),
    .i_set_sel    (sel),
    .i_set_mode   (mode),
    .i_set_val    (val),
    .i_duration   (dur),
    .o_set_signals(sig),
    .o_busy       (busy),
    .o_set_done   (done),
    .o_set_err    (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Model: outputs visible in cycle c+1 follow from inputs held during cycle c.
  initial begin
    longint c;
    longint d;
    logic   completing;
    forever begin
      @(posedge clk);
      c = cyc;
      cyc = cyc + 1;
      m_done = 1'b0;
      m_err  = 1'b0;
      if (rst) begin
        m_sig = '0;
        m_end = 0;
      end else begin
        completing = (m_end == c + 1);
        if (completing) begin
          m_sig[m_sel] = m_val;
          m_done = 1'b1;
        end
        if (en) begin
          if (c >= m_end && sel < 3'd5 && mode != 2'b11) begin
            d = (dur == 0) ? 1 : longint'(dur);
            case (mode)
              2'b00: begin
                m_sig[sel] = val;
                m_done = 1'b1;
              end
              2'b01: begin
                m_sel = int'(sel);
                m_val = m_sig[sel];
                m_sig[sel] = val;
                m_end = c + 1 + d;
              end
              default: begin
                m_sel = int'(sel);
                m_val = val;
                m_end = c + 1 + d;
              end
            endcase
          end else if (!completing) begin
            m_err = 1'b1;
          end
        end
      end
    end
  end

  // Compare process, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (cyc >= 1) begin
        chk("model_sig",  64'(sig),  64'(m_sig));
        chk("model_busy", 64'(busy), 64'(cyc < m_end));
        chk("model_done", 64'(done), 64'(m_done));
        chk("model_err",  64'(err),  64'(m_err));
        chk("done_err_exclusive", 64'(done & err), 64'd0);
      end
    end
  end

  task automatic at_cycle(input longint n);
    while (cyc < n) @(posedge clk);
    #1;
  endtask

  task automatic cmd(input logic [2:0] s, input logic [1:0] m, input logic v, input logic [31:0] d);
    en = 1'b1; sel = s; mode = m; val = v; dur = d;
    $display("cycle %0d: cmd sel=%0d mode=%0d val=%0d dur=%0h", cyc, s, m, v, d);
  endtask

  initial begin
    at_cycle(3);
    chk("reset_sig", 64'(sig), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    rst = 1'b0;

    at_cycle(10); cmd(3'd2, 2'b00, 1'b1, 32'd0);
    at_cycle(11); en = 1'b0;
    chk("set_sig", 64'(sig), 64'b00100);
    chk("set_done", 64'(done), 64'd1);
    chk("set_busy", 64'(busy), 64'd0);
    at_cycle(12);
    chk("set_done_drop", 64'(done), 64'd0);

    at_cycle(20); cmd(3'd0, 2'b01, 1'b1, 32'd4);
    at_cycle(21); en = 1'b0;
    chk("pulse_first_sig", 64'(sig), 64'b00101);
    chk("pulse_first_busy", 64'(busy), 64'd1);
    at_cycle(24);
    chk("pulse_last_sig", 64'(sig), 64'b00101);
    at_cycle(25);
    chk("pulse_restore_sig", 64'(sig), 64'b00100);
    chk("pulse_done", 64'(done), 64'd1);
    chk("pulse_busy_end", 64'(busy), 64'd0);

    at_cycle(30); cmd(3'd4, 2'b10, 1'b1, 32'd0);
    at_cycle(31); en = 1'b0;
    chk("delay_wait_sig", 64'(sig), 64'b00100);
    chk("delay_wait_busy", 64'(busy), 64'd1);
    at_cycle(32);
    chk("delay_sig", 64'(sig), 64'b10100);
    chk("delay_done", 64'(done), 64'd1);

    at_cycle(40); cmd(3'd5, 2'b00, 1'b1, 32'd0);
    at_cycle(41); en = 1'b0;
    chk("badsel_err", 64'(err), 64'd1);
    at_cycle(42); cmd(3'd1, 2'b11, 1'b1, 32'd0);
    at_cycle(43); en = 1'b0;
    chk("rsvd_err", 64'(err), 64'd1);
    chk("rsvd_sig", 64'(sig), 64'b10100);

    at_cycle(50); cmd(3'd3, 2'b01, 1'b1, 32'd10);
    at_cycle(51); en = 1'b0;
    chk("long_pulse_sig", 64'(sig), 64'b11100);
    at_cycle(55); cmd(3'd1, 2'b00, 1'b1, 32'd0);
    at_cycle(56); en = 1'b0;
    chk("busy_strobe_err", 64'(err), 64'd1);
    chk("busy_strobe_sig", 64'(sig), 64'b11100);
    at_cycle(60); cmd(3'd1, 2'b00, 1'b1, 32'd0);
    at_cycle(61); cmd(3'd1, 2'b00, 1'b1, 32'd0);
    chk("complete_strobe_done", 64'(done), 64'd1);
    chk("complete_strobe_err", 64'(err), 64'd0);
    chk("complete_strobe_sig", 64'(sig), 64'b10100);
    at_cycle(62); en = 1'b0;
    chk("back_to_back_sig", 64'(sig), 64'b10110);
    chk("back_to_back_done", 64'(done), 64'd1);

    at_cycle(70); cmd(3'd1, 2'b01, 1'b0, 32'd8);
    at_cycle(71); en = 1'b0;
    chk("abort_pulse_sig", 64'(sig), 64'b10100);
    at_cycle(73); rst = 1'b1;
    at_cycle(74); rst = 1'b0;
    chk("abort_sig", 64'(sig), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);

    at_cycle(80); cmd(3'd1, 2'b00, 1'b1, 32'd0);
    at_cycle(81); en = 1'b0;
    chk("post_abort_sig", 64'(sig), 64'b00010);
    chk("post_abort_done", 64'(done), 64'd1);

    at_cycle(85); cmd(3'd2, 2'b01, 1'b1, 32'd1);
    at_cycle(86); en = 1'b0;
    chk("pulse1_sig", 64'(sig), 64'b00110);
    at_cycle(87);
    chk("pulse1_restore", 64'(sig), 64'b00010);
    chk("pulse1_done", 64'(done), 64'd1);

    at_cycle(90); cmd(3'd0, 2'b10, 1'b1, 32'd3);
    at_cycle(91); en = 1'b0;
    at_cycle(93);
    chk("delay3_wait", 64'(sig), 64'b00010);
    at_cycle(94);
    chk("delay3_sig", 64'(sig), 64'b00011);

    at_cycle(100); cmd(3'd3, 2'b10, 1'b1, 32'hFFFF_FFFF);
    at_cycle(101); en = 1'b0;
    at_cycle(104);
    chk("maxdur_busy", 64'(busy), 64'd1);
    at_cycle(105); rst = 1'b1; cmd(3'd0, 2'b00, 1'b1, 32'd0);
    at_cycle(106); rst = 1'b0; en = 1'b0;
    chk("rst_ignores_strobe", 64'(sig), 64'd0);
    chk("maxdur_abort_busy", 64'(busy), 64'd0);

    at_cycle(112);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
